uart_receiver: RTL and testbench
================================

# uart_receiver

- Recovers 8-bit bytes from an asynchronous serial line using 16× oversampling.
- Frame: 1 start bit, 8 data bits LSB first, optional even parity, 1 stop bit.
- Delivers each good byte with a one-cycle valid strobe. Its held data output feeds the four-digit LED driver's `Data_in`, so the display shows the last byte received.

## Interface
- `BAUD_DIV`, default 27: clock cycles per oversample tick (50 MHz / (115200 × 16) ≈ 27).
- `PARITY_EN`, default 1: 1 means the frame carries an even-parity bit; 0 means no parity bit.
- `clock` in, 1: system clock, rising edge.
- `reset` in, 1: asynchronous, active-high.
- `Rx_EN` in, 1: receiver enable. While 0, the FSM is held in IDLE.
- `RxD` in, 1: serial line, idles high, asynchronous to `clock`.
- `Rx_DATA` out, 8: last good byte, held until the next good frame.
- `Rx_VALID` out, 1: one-cycle pulse when `Rx_DATA` has just been updated.
- `Rx_PERROR` out, 1: one-cycle pulse, parity mismatch.
- `Rx_FERROR` out, 1: one-cycle pulse, stop bit sampled low.

## Operation
- **Input synchronizer:** `RxD` passes through a 2-flop synchronizer that resets to 1. All logic uses the synchronized copy.
- **Tick generator:** counts 0..`BAUD_DIV`-1 and emits `tick` on terminal count. It is held cleared while the FSM is in IDLE.
- **Sample counter:** 4 bits, counts ticks within the current bit.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:**
  - Go to START on a synchronized falling edge (previous 1, current 0) while `Rx_EN`=1.
  - Tick generator and sample counter are cleared.
- **START:**
  - On the 8th tick (mid start bit), sample the line.
  - Line 0: go to DATA and reset the sample counter.
  - Line 1 (false start): return to IDLE. No outputs change.
- **DATA:**
  - On every 16th tick, shift the sampled bit in at bit 7 of a shift register (LSB arrives first).
  - A 3-bit bit counter tracks progress. After bit 7, go to PARITY if `PARITY_EN`, else to STOP.
- **PARITY:** on the 16th tick, sample the parity bit and go to STOP.
- **STOP:**
  - On the 16th tick, sample the stop bit and evaluate the frame.
  - Stop bit = 0: pulse `Rx_FERROR`.
  - `PARITY_EN` and (XOR of data ^ parity bit) = 1: pulse `Rx_PERROR`.
  - No error: load `Rx_DATA` and pulse `Rx_VALID`.
  - Return to IDLE in all cases.
- **Error frames:** `Rx_DATA` is never modified by an errored frame. Both error pulses may assert in the same cycle.
- **Disable mid-frame:** `Rx_EN` dropping to 0 forces IDLE on the next edge and discards the partial frame, with no pulses.
- **Reset values:**
  - `Rx_DATA`=8'h00; `Rx_VALID`, `Rx_PERROR`, `Rx_FERROR`=0.
  - FSM=IDLE; counters=0; synchronizer=2'b11.
- **Reset mid-frame:** all state returns to the above immediately. Any partial frame is lost.

## Timing
- Latency from a raw `RxD` edge to its synchronized copy: 2 clocks.
- Let E be the clock edge at which the synchronized falling edge is detected. The start bit is sampled 8 ticks after E, i.e. at 8×`BAUD_DIV` clocks.
- Result pulses (`Rx_VALID`, `Rx_PERROR`, `Rx_FERROR`) assert at:
  - E + 168×`BAUD_DIV` + 1 clocks with parity enabled (start 8 ticks + 8 data × 16 + parity 16 + stop 16).
  - E + 152×`BAUD_DIV` + 1 clocks with `PARITY_EN`=0.
- Each result pulse lasts exactly 1 clock. `Rx_DATA` changes on the same edge `Rx_VALID` rises.
- **Back-to-back frames:**
  - The FSM re-enters IDLE at the stop-bit midpoint.
  - A falling edge occurring ≥1 clock after the stop sample is accepted, so zero idle bits between frames are supported.
  - Sender tolerated baud mismatch: ±3 %.

## Structure
- Shared package `uart_pkg`:
  - FSM state typedef (IDLE, START, DATA, PARITY, STOP).
  - Constants: `OVERSAMPLE`=16, `MID_SAMPLE`=8, `DATA_BITS`=8.
  - Default `BAUD_DIV`.
- One sub-module, `baud_tick_gen` (inputs `clock`, `reset`, `clear`; output `tick`), so the future transmitter can reuse it.

## Test plan
1. Frame 0xA5 with parity bit 0 and stop bit 1, `BAUD_DIV`=27 → `Rx_VALID` pulses once at E+4537 clocks, `Rx_DATA`=0xA5, no error pulses.
2. Frame 0x3C with parity bit 1 (wrong) → `Rx_PERROR` pulses once, `Rx_VALID` stays 0, `Rx_DATA` keeps 0xA5.
3. Frame 0x81 with stop bit 0 → `Rx_FERROR` pulses once, `Rx_DATA` unchanged.
4. `RxD` low glitch of 4 ticks (108 clocks) → FSM returns to IDLE, no output pulses. A following valid 0x55 frame is received correctly.
5. Back-to-back 0x00 then 0xFF with no idle bit between → two `Rx_VALID` pulses, 11 bit times (4752 clocks) apart, data 0x00 then 0xFF.
6. Assert `reset` during data bit 4 of frame 0x12, release, then send 0x34 → no pulse for 0x12, all outputs read reset values during reset, then `Rx_DATA`=0x34 with `Rx_VALID`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states and frame/oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DATA_BITS = 8;
  localparam int DEFAULT_BAUD_DIV = 27;

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one registered tick every BAUD_DIV clocks.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(BAUD_DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 16x oversampling UART receiver: 8 data bits, LSB first,
// optional even parity, one stop bit.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
  parameter int PARITY_EN = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  state_t     state;
  logic [1:0] sync;
  logic       rx_prev;
  logic [3:0] scnt;
  logic [2:0] bcnt;
  logic [7:0] shreg;
  logic       par_bit;
  logic       tick;
  logic       rx;
  logic       fall;
  logic       bit_end;
  logic       par_err;

  assign rx      = sync[1];
  assign fall    = rx_prev & ~rx;
  assign bit_end = tick && (scnt == 4'(OVERSAMPLE - 1));
  assign par_err = (PARITY_EN != 0) && ((^shreg) ^ par_bit);

  baud_tick_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .clear(state == IDLE),
    .tick (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync      <= 2'b11;
      rx_prev   <= 1'b1;
      state     <= IDLE;
      scnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      Rx_DATA   <= '0;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else begin
      sync      <= {sync[0], RxD};
      rx_prev   <= rx;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
      if (!Rx_EN) begin
        state <= IDLE;
        scnt  <= '0;
        bcnt  <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            scnt <= '0;
            bcnt <= '0;
            if (fall) state <= START;
          end
          START: begin
            if (tick) begin
              if (scnt == 4'(MID_SAMPLE - 1)) begin
                // Mid start bit: a high line here is a glitch
                scnt  <= '0;
                state <= rx ? IDLE : DATA;
              end else begin
                scnt <= scnt + 4'd1;
              end
            end
          end
          DATA: begin
            if (tick) scnt <= scnt + 4'd1;
            if (bit_end) begin
              shreg <= {rx, shreg[7:1]};
              bcnt  <= bcnt + 3'd1;
              if (bcnt == 3'(DATA_BITS - 1))
                state <= (PARITY_EN != 0) ? PARITY : STOP;
            end
          end
          PARITY: begin
            if (tick) scnt <= scnt + 4'd1;
            if (bit_end) begin
              par_bit <= rx;
              state   <= STOP;
            end
          end
          STOP: begin
            if (tick) scnt <= scnt + 4'd1;
            if (bit_end) begin
              state     <= IDLE;
              Rx_FERROR <= ~rx;
              Rx_PERROR <= par_err;
              if (rx && !par_err) begin
                Rx_DATA  <= shreg;
                Rx_VALID <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver at BAUD_DIV=27, even parity.
module tb_uart_receiver;

  localparam int BIT = 16 * 27;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       Rx_EN = 1'b1;
  logic       RxD = 1'b1;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int vcnt = 0;
  int pcnt = 0;
  int fcnt = 0;
  int vcyc = 0;
  int vcyc_prev = 0;
  logic [7:0] vdata = 8'h00;
  logic [7:0] vdata_prev = 8'h00;

  uart_receiver #(
    .BAUD_DIV (27),
    .PARITY_EN(1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .Rx_EN    (Rx_EN),
    .RxD      (RxD),
    .Rx_DATA  (Rx_DATA),
    .Rx_VALID (Rx_VALID),
    .Rx_PERROR(Rx_PERROR),
    .Rx_FERROR(Rx_FERROR)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (Rx_VALID) begin
      vcnt++;
      vcyc_prev = vcyc;
      vcyc = cyc;
      vdata_prev = vdata;
      vdata = Rx_DATA;
    end
    if (Rx_PERROR) pcnt++;
    if (Rx_FERROR) fcnt++;
  end

  task automatic drive_bit(input logic b);
    RxD = b;
    repeat (BIT) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic s);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
    RxD = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    RxD = 1'b1;
    Rx_EN = 1'b1;
    repeat (3) @(negedge clock);
    tests++;
    if (Rx_DATA !== 8'h00) begin
      fails++;
      $display("FAIL reset_data: got %h expected 00", Rx_DATA);
    end
    tests++;
    if (Rx_VALID !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid: got %b expected 0", Rx_VALID);
    end
    tests++;
    if (Rx_PERROR !== 1'b0) begin
      fails++;
      $display("FAIL reset_perror: got %b expected 0", Rx_PERROR);
    end
    tests++;
    if (Rx_FERROR !== 1'b0) begin
      fails++;
      $display("FAIL reset_ferror: got %b expected 0", Rx_FERROR);
    end
    reset = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_good_frame();
    int v0, p0, f0;
    v0 = vcnt; p0 = pcnt; f0 = fcnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    repeat (20) @(negedge clock);
    tests++;
    if (vcnt - v0 !== 1) begin
      fails++;
      $display("FAIL good_valid_count: got %0d expected 1", vcnt - v0);
    end
    // 2 sync clocks + 1 detect clock + 168*27+1
    tests++;
    if (vcyc - start_cyc !== 4540) begin
      fails++;
      $display("FAIL good_latency: got %0d expected 4540",
               vcyc - start_cyc);
    end
    tests++;
    if (Rx_DATA !== 8'hA5) begin
      fails++;
      $display("FAIL good_data: got %h expected a5", Rx_DATA);
    end
    tests++;
    if (pcnt - p0 !== 0 || fcnt - f0 !== 0) begin
      fails++;
      $display("FAIL good_errors: got p=%0d f=%0d expected 0 0",
               pcnt - p0, fcnt - f0);
    end
  endtask

  task automatic test_parity_error();
    int v0, p0, f0;
    v0 = vcnt; p0 = pcnt; f0 = fcnt;
    send_frame(8'h3C, 1'b1, 1'b1);
    repeat (20) @(negedge clock);
    tests++;
    if (pcnt - p0 !== 1) begin
      fails++;
      $display("FAIL perr_count: got %0d expected 1", pcnt - p0);
    end
    tests++;
    if (vcnt - v0 !== 0 || fcnt - f0 !== 0) begin
      fails++;
      $display("FAIL perr_other: got v=%0d f=%0d expected 0 0",
               vcnt - v0, fcnt - f0);
    end
    tests++;
    if (Rx_DATA !== 8'hA5) begin
      fails++;
      $display("FAIL perr_data: got %h expected a5", Rx_DATA);
    end
  endtask

  task automatic test_framing_error();
    int v0, p0, f0;
    v0 = vcnt; p0 = pcnt; f0 = fcnt;
    send_frame(8'h81, 1'b0, 1'b0);
    repeat (BIT) @(negedge clock);
    tests++;
    if (fcnt - f0 !== 1) begin
      fails++;
      $display("FAIL ferr_count: got %0d expected 1", fcnt - f0);
    end
    tests++;
    if (vcnt - v0 !== 0 || pcnt - p0 !== 0) begin
      fails++;
      $display("FAIL ferr_other: got v=%0d p=%0d expected 0 0",
               vcnt - v0, pcnt - p0);
    end
    tests++;
    if (Rx_DATA !== 8'hA5) begin
      fails++;
      $display("FAIL ferr_data: got %h expected a5", Rx_DATA);
    end
  endtask

  task automatic test_glitch();
    int v0, p0, f0;
    v0 = vcnt; p0 = pcnt; f0 = fcnt;
    RxD = 1'b0;
    repeat (108) @(negedge clock);
    RxD = 1'b1;
    repeat (600) @(negedge clock);
    tests++;
    if (vcnt - v0 !== 0 || pcnt - p0 !== 0 || fcnt - f0 !== 0) begin
      fails++;
      $display("FAIL glitch_pulses: got v=%0d p=%0d f=%0d expected 0 0 0",
               vcnt - v0, pcnt - p0, fcnt - f0);
    end
    send_frame(8'h55, 1'b0, 1'b1);
    repeat (20) @(negedge clock);
    tests++;
    if (vcnt - v0 !== 1 || Rx_DATA !== 8'h55) begin
      fails++;
      $display("FAIL glitch_next: got v=%0d data=%h expected 1 55",
               vcnt - v0, Rx_DATA);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = vcnt;
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    repeat (20) @(negedge clock);
    tests++;
    if (vcnt - v0 !== 2) begin
      fails++;
      $display("FAIL b2b_count: got %0d expected 2", vcnt - v0);
    end
    tests++;
    if (vcyc - vcyc_prev !== 4752) begin
      fails++;
      $display("FAIL b2b_spacing: got %0d expected 4752",
               vcyc - vcyc_prev);
    end
    tests++;
    if (vdata_prev !== 8'h00 || vdata !== 8'hFF) begin
      fails++;
      $display("FAIL b2b_data: got %h %h expected 00 ff",
               vdata_prev, vdata);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0, p0, f0;
    logic [7:0] d;
    d = 8'h12;
    v0 = vcnt; p0 = pcnt; f0 = fcnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    RxD = d[4];
    repeat (200) @(negedge clock);
    reset = 1'b1;
    RxD = 1'b1;
    repeat (2) @(negedge clock);
    tests++;
    if (Rx_DATA !== 8'h00 || Rx_VALID !== 1'b0 ||
        Rx_PERROR !== 1'b0 || Rx_FERROR !== 1'b0) begin
      fails++;
      $display("FAIL midreset_outputs: got %h %b %b %b expected 00 0 0 0",
               Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR);
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    send_frame(8'h34, 1'b1, 1'b1);
    repeat (20) @(negedge clock);
    tests++;
    if (vcnt - v0 !== 1 || Rx_DATA !== 8'h34) begin
      fails++;
      $display("FAIL midreset_next: got v=%0d data=%h expected 1 34",
               vcnt - v0, Rx_DATA);
    end
    tests++;
    if (pcnt - p0 !== 0 || fcnt - f0 !== 0) begin
      fails++;
      $display("FAIL midreset_errors: got p=%0d f=%0d expected 0 0",
               pcnt - p0, fcnt - f0);
    end
  endtask

  task automatic test_disable();
    int v0, p0, f0;
    logic [7:0] d;
    d = 8'h77;
    v0 = vcnt; p0 = pcnt; f0 = fcnt;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    Rx_EN = 1'b0;
    for (int i = 3; i < 8; i++) drive_bit(d[i]);
    drive_bit(1'b0);
    drive_bit(1'b1);
    repeat (20) @(negedge clock);
    Rx_EN = 1'b1;
    repeat (20) @(negedge clock);
    tests++;
    if (vcnt - v0 !== 0 || pcnt - p0 !== 0 || fcnt - f0 !== 0) begin
      fails++;
      $display("FAIL disable_pulses: got v=%0d p=%0d f=%0d expected 0 0 0",
               vcnt - v0, pcnt - p0, fcnt - f0);
    end
    tests++;
    if (Rx_DATA !== 8'h34) begin
      fails++;
      $display("FAIL disable_data: got %h expected 34", Rx_DATA);
    end
    send_frame(8'h0F, 1'b0, 1'b1);
    repeat (20) @(negedge clock);
    tests++;
    if (vcnt - v0 !== 1 || Rx_DATA !== 8'h0F) begin
      fails++;
      $display("FAIL disable_next: got v=%0d data=%h expected 1 0f",
               vcnt - v0, Rx_DATA);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_framing_error();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_disable();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
